sim_run_ctrl: RTL and testbench

- Reusable run-control block for CPU simulation benches; replaces hand-timed reset pulses and fixed-delay stop.
- Sits between the bench's clock/reset sources and the CPU top.
- Sequences CPU reset, counts cycles and retired instructions, and detects program end (halt word or PC self-loop) or a timeout watchdog.
- Reports sticky done/halted/timeout status to the bench.

---
 rtl/sim_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_sim_run_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// Run-control block for CPU simulation benches: sequences CPU reset, counts RUN cycles and
// retires, and ends the run on a halt word, a PC self-loop or a watchdog. Optional trace: SIM_RUN_TRACE_EN.
module sim_run_ctrl #(
    parameter int          RST_CYCLES  = 4,
    parameter int          MAX_CYCLES  = 70,
    parameter int          STALL_LIMIT = 8,
    parameter logic [31:0] HALT_WORD   = 32'h1000FFFF,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             retire,
    output logic             cpu_reset,
    output logic             run,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [7:0]         hold_cnt_r, hold_cnt_s;
    logic [CNT_W-1:0]   cycle_cnt_r, cycle_cnt_s;
    logic [CNT_W-1:0]   instr_cnt_r, instr_cnt_s;
    logic [31:0]        stall_cnt_r, stall_cnt_s;
    logic [31:0]        last_pc_r, last_pc_s;
    logic               done_r, done_s;
    logic               halted_r, halted_s;
    logic               timeout_r, timeout_s;
    logic               halt_hit_s, stall_hit_s, timeout_hit_s;

    // Next-state and counter update; halt detection wins over the watchdog in the same cycle.
    always_comb begin
        state_s       = state_r;
        hold_cnt_s    = hold_cnt_r;
        cycle_cnt_s   = cycle_cnt_r;
        instr_cnt_s   = instr_cnt_r;
        stall_cnt_s   = stall_cnt_r;
        last_pc_s     = last_pc_r;
        done_s        = done_r;
        halted_s      = halted_r;
        timeout_s     = timeout_r;
        halt_hit_s    = 1'b0;
        stall_hit_s   = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_HOLD: begin
                hold_cnt_s = hold_cnt_r + 8'd1;
                if (hold_cnt_r == 8'(RST_CYCLES - 1)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_RUN: begin
                cycle_cnt_s   = cycle_cnt_r + CNT_W'(1);
                timeout_hit_s = (cycle_cnt_r == CNT_W'(MAX_CYCLES - 1));
                if (retire) begin
                    instr_cnt_s = instr_cnt_r + CNT_W'(1);
                    halt_hit_s  = (instr == HALT_WORD);
                    // A retire at the same PC extends the self-loop run; a new PC restarts it.
                    if (pc == last_pc_r) begin
                        stall_cnt_s = stall_cnt_r + 32'd1;
                        stall_hit_s = (stall_cnt_r == 32'(STALL_LIMIT - 2));
                    end else begin
                        stall_cnt_s = 32'd0;
                        last_pc_s   = pc;
                    end
                end else begin
                    instr_cnt_s = instr_cnt_r;
                end
                if (halt_hit_s || stall_hit_s) begin
                    state_s  = ST_DONE;
                    done_s   = 1'b1;
                    halted_s = 1'b1;
                end else if (timeout_hit_s) begin
                    state_s   = ST_DONE;
                    done_s    = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_HOLD;
            end
        endcase
    end

    // State, counter and sticky-flag registers with synchronous bench reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HOLD;
            hold_cnt_r  <= 8'd0;
            cycle_cnt_r <= '0;
            instr_cnt_r <= '0;
            stall_cnt_r <= 32'd0;
            last_pc_r   <= 32'd0;
            done_r      <= 1'b0;
            halted_r    <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_cnt_r  <= hold_cnt_s;
            cycle_cnt_r <= cycle_cnt_s;
            instr_cnt_r <= instr_cnt_s;
            stall_cnt_r <= stall_cnt_s;
            last_pc_r   <= last_pc_s;
            done_r      <= done_s;
            halted_r    <= halted_s;
            timeout_r   <= timeout_s;
        end
    end

`ifdef SIM_RUN_TRACE_EN
    // Retire trace and end-of-run summary for interactive debugging.
    always_ff @(posedge clk) begin
        if (!reset && state_r == ST_RUN && retire) begin
            $display("[sim_run_ctrl] cyc=%h pc=%h instr=%h", cycle_cnt_r, pc, instr);
        end
        if (!reset && state_r == ST_RUN && state_s == ST_DONE) begin
            $display("[sim_run_ctrl] end of run: halted=%0d timeout=%0d cycles=%h instrs=%h",
                     halted_s, timeout_s, cycle_cnt_s, instr_cnt_s);
            $stop;
        end
    end
`else
    // Trace disabled: the bench polls done.
`endif

    assign cpu_reset = (state_r == ST_HOLD);
    assign run       = (state_r == ST_RUN);
    assign done      = done_r;
    assign halted    = halted_r;
    assign timeout   = timeout_r;
    assign cycle_cnt = cycle_cnt_r;
    assign instr_cnt = instr_cnt_r;
    assign state     = state_r;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl: a directed vector table plus hand-written multi-cycle scenarios.
module tb_sim_run_ctrl;

    localparam logic [31:0] HALT = 32'h1000FFFF;
    localparam logic [31:0] NOP  = 32'h20420001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        retire = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] instr = 32'd0;
    logic        cpu_reset, run, done, halted, timeout;
    logic [31:0] cycle_cnt, instr_cnt;
    logic [1:0]  state;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    sim_run_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .retire    (retire),
        .cpu_reset (cpu_reset),
        .run       (run),
        .done      (done),
        .halted    (halted),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt),
        .state     (state)
    );

    typedef struct {
        logic        rst;
        logic        ret;
        logic [31:0] pcv;
        logic [31:0] ins;
        logic [1:0]  st;
        logic        cr, rn, dn, hl, to;
        logic [31:0] cyc, icnt;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic r, logic rt, logic [31:0] p, logic [31:0] i, logic [1:0] s,
                                logic cr, logic rn, logic dn, logic hl, logic to,
                                logic [31:0] cyc, logic [31:0] ic);
        vec_t v;
        v.rst = r; v.ret = rt; v.pcv = p; v.ins = i; v.st = s;
        v.cr = cr; v.rn = rn; v.dn = dn; v.hl = hl; v.to = to;
        v.cyc = cyc; v.icnt = ic;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic cr, input logic rn,
                           input logic dn, input logic hl, input logic to,
                           input logic [31:0] cyc, input logic [31:0] ic);
        chk({tag, ".state"},     {30'd0, state},     {30'd0, st});
        chk({tag, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cr});
        chk({tag, ".run"},       {31'd0, run},       {31'd0, rn});
        chk({tag, ".done"},      {31'd0, done},      {31'd0, dn});
        chk({tag, ".halted"},    {31'd0, halted},    {31'd0, hl});
        chk({tag, ".timeout"},   {31'd0, timeout},   {31'd0, to});
        chk({tag, ".cycle_cnt"}, cycle_cnt, cyc);
        chk({tag, ".instr_cnt"}, instr_cnt, ic);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; retire = 1'b0; pc = 32'd0; instr = 32'd0;
        repeat (3) step();
        chk_all({tag, ".rst"}, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
    endtask

    // cpu_reset stays high for four edges after reset falls; RUN is entered on the fourth.
    task automatic hold_seq(input string tag);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all({tag, ".hold"}, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        step();
        chk_all({tag, ".run_entry"}, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic drive(input int mode, input int c);
        reset  = 1'b0;
        retire = 1'b1;
        pc     = 32'h400 + 32'(c) * 32'd4;
        instr  = NOP;
        case (mode)
            0: instr = (c == 10) ? HALT : NOP;
            1: pc = (c < 5) ? 32'h400 + 32'(c) * 32'd4 : 32'h20;
            2: retire = ((c % 2) == 0);
            3: instr = (c == 69) ? HALT : NOP;
            default: instr = NOP;
        endcase
    endtask

    task automatic run_scen(input int mode, input string tag, input logic [31:0] ecyc,
                            input logic [31:0] eins, input logic eh, input logic et);
        int c;
        do_reset(tag);
        hold_seq(tag);
        c = 0;
        while (done !== 1'b1 && c < 200) begin
            drive(mode, c);
            step();
            c++;
        end
        chk_all({tag, ".end"}, 2'd2, 1'b0, 1'b0, 1'b1, eh, et, ecyc, eins);
        // Inputs must be ignored once DONE.
        retire = 1'b1; pc = 32'h40; instr = HALT;
        repeat (3) step();
        chk_all({tag, ".frozen"}, 2'd2, 1'b0, 1'b0, 1'b1, eh, et, ecyc, eins);
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,   32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[1]  = mk(1'b1, 1'b1, 32'h8,   HALT,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[2]  = mk(1'b1, 1'b0, 32'h0,   32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[3]  = mk(1'b0, 1'b1, 32'h4,   HALT,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[4]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[5]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[6]  = mk(1'b0, 1'b0, 32'h0,   32'h0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tbl[7]  = mk(1'b0, 1'b1, 32'h100, NOP,   2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        tbl[8]  = mk(1'b0, 1'b0, 32'h104, HALT,  2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 32'd1);
        tbl[9]  = mk(1'b0, 1'b1, 32'h104, HALT,  2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 32'd2);
        tbl[10] = mk(1'b0, 1'b1, 32'h200, NOP,   2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 32'd2);
        tbl[11] = mk(1'b1, 1'b1, 32'h200, NOP,   2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; retire = tbl[i].ret; pc = tbl[i].pcv; instr = tbl[i].ins;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].cr, tbl[i].rn, tbl[i].dn,
                    tbl[i].hl, tbl[i].to, tbl[i].cyc, tbl[i].icnt);
        end

        run_scen(0, "halt_word", 32'd11, 32'd11, 1'b1, 1'b0);
        run_scen(1, "pc_stall",  32'd13, 32'd13, 1'b1, 1'b0);
        run_scen(2, "timeout",   32'd70, 32'd35, 1'b0, 1'b1);
        run_scen(3, "halt_vs_timeout", 32'd70, 32'd70, 1'b1, 1'b0);

        // Reset in the middle of a run discards all progress.
        do_reset("midrst");
        hold_seq("midrst");
        for (int c = 0; c < 20; c++) begin
            drive(4, c);
            step();
        end
        chk_all("midrst.before", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd20, 32'd20);
        reset = 1'b1;
        step();
        chk_all("midrst.reset_edge", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        hold_seq("midrst.rerun");
        for (int c = 0; c < 3; c++) begin
            drive(4, c);
            step();
        end
        chk_all("midrst.restart", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
